// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - MEM-stage load/store controller driving the shared system bus handshake.
// Optional ACCESS-state timeout abort is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [31:0] ex_out,
  output logic [31:0] out,
  output logic        miss_align,
  output logic        busy,
  output logic        bus_req_,
  input  logic        bus_grant_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  localparam logic [1:0] OP_LDW = 2'b01;
  localparam logic [1:0] OP_STW = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] rd_buf;
  logic        mem_acc;
  logic        valid;
  logic        done;
  logic        expire;

  assign mem_acc    = ex_en & ((ex_mem_op == OP_LDW) | (ex_mem_op == OP_STW));
  assign miss_align = mem_acc & (ex_mem_addr[1:0] != 2'b00);
  assign valid      = mem_acc & ~miss_align & ~flush;
  assign done       = (state == ACCESS) & ~bus_rdy_;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;

  // Completion wins over expiry because expire requires bus_rdy_ still high.
  assign expire = (state == ACCESS) & bus_rdy_ & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= expire;
      if (state == REQ)
        tmo_cnt <= 8'd0;
      else if (state == ACCESS && bus_rdy_)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign bus_err            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = REQ;
      REQ: begin
        if (flush)
          state_nxt = IDLE;
        else if (!bus_grant_)
          state_nxt = ACCESS;
      end
      ACCESS: begin
        if (done)
          state_nxt = stall ? STALL : IDLE;
        else if (expire)
          state_nxt = IDLE;
      end
      STALL:   if (!stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    out  = 32'd0;
    case (state)
      IDLE: begin
        busy = valid;
        out  = mem_acc ? 32'd0 : ex_out;
      end
      REQ:    busy = 1'b1;
      ACCESS: begin
        busy = ~done & ~expire;
        if (done && bus_rw)
          out = bus_rd_data;
      end
      STALL:  if (bus_rw) out = rd_buf;
      default: ;
    endcase
  end

  // Bus strobes are registered; address strobe falls for the first ACCESS cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= 30'd0;
      bus_wr_data <= 32'd0;
      rd_buf      <= 32'd0;
    end else begin
      bus_as_ <= 1'b1;
      case (state)
        IDLE: begin
          if (valid) begin
            bus_req_    <= 1'b0;
            bus_addr    <= ex_mem_addr[31:2];
            bus_rw      <= (ex_mem_op == OP_LDW);
            bus_wr_data <= ex_mem_wr_data;
          end
        end
        REQ: begin
          if (flush)
            bus_req_ <= 1'b1;
          else if (!bus_grant_)
            bus_as_ <= 1'b0;
        end
        ACCESS: begin
          if (done) begin
            bus_req_ <= 1'b1;
            rd_buf   <= bus_rd_data;
          end else if (expire) begin
            bus_req_ <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl.
module tb_mem_bus_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_en;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wr_data;
  logic [31:0] ex_out;
  logic [31:0] out;
  logic        miss_align;
  logic        busy;
  logic        bus_req_;
  logic        bus_grant_;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_en(ex_en),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_out(ex_out), .out(out), .miss_align(miss_align), .busy(busy),
    .bus_req_(bus_req_), .bus_grant_(bus_grant_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_en          = 1'b0;
    ex_mem_op      = 2'( 32'($urandom_range(0, 3)));
    ex_mem_addr    = $urandom;
    ex_mem_wr_data = $urandom;
    ex_out         = $urandom;
    flush          = 1'b0;
    stall          = 1'b0;
    bus_grant_     = 1'b1;
    bus_rdy_       = 1'b1;
    bus_rd_data    = $urandom;
  endtask

  task automatic pass_through(input logic en, input logic [1:0] op, input logic [31:0] val);
    idle_in();
    ex_en     = en;
    ex_mem_op = op;
    ex_out    = val;
    @(negedge clk);
    check("alu_out", out, val);
    check("alu_busy", busy, 1'b0);
    check("alu_req", bus_req_, 1'b1);
    check("alu_misalign", miss_align, 1'b0);
    tick();
  endtask

  task automatic misaligned(input logic load, input logic [31:0] addr, input logic fl);
    idle_in();
    ex_en       = 1'b1;
    ex_mem_op   = load ? 2'b01 : 2'b10;
    ex_mem_addr = addr;
    flush       = fl;
    @(negedge clk);
    check("mis_flag", miss_align, 1'b1);
    check("mis_out", out, 32'd0);
    check("mis_busy", busy, 1'b0);
    tick();
    idle_in();
    @(negedge clk);
    check("mis_no_req", bus_req_, 1'b1);
    check("mis_no_as", bus_as_, 1'b1);
    tick();
  endtask

  // Timeline: k=0 issue in IDLE, g extra REQ cycles before grant, r extra ACCESS cycles before rdy,
  // completion at c=2+g+r, then s cycles held in STALL.
  task automatic run_access(input logic load, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int g, input int r, input int s,
                            input logic flush_acc);
    int c;
    int as_cnt;
    int busy_cnt;
    logic [31:0] exp_res;
    c        = 2 + g + r;
    as_cnt   = 0;
    busy_cnt = 0;
    exp_res  = load ? rdata : 32'd0;
    idle_in();
    ex_en          = 1'b1;
    ex_mem_op      = load ? 2'b01 : 2'b10;
    ex_mem_addr    = addr;
    ex_mem_wr_data = wdata;
    for (int k = 0; k <= c + s; k++) begin
      bus_grant_  = !(k >= 1 + g && k <= c);
      bus_rdy_    = (k != c);
      bus_rd_data = (k == c) ? rdata : $urandom;
      stall       = (k >= c && k < c + s);
      flush       = flush_acc && (k == g + 2);
      if (k > c) ex_en = 1'b0;
      @(negedge clk);
      if (!bus_as_) begin
        as_cnt++;
        check("as_pos", k, g + 2);
        check("as_addr", {2'b00, bus_addr}, {2'b00, addr[31:2]});
        check("as_rw", bus_rw, load);
        check("as_wdata", bus_wr_data, wdata);
      end
      if (busy) busy_cnt++;
      if (k >= 1) check("req_level", bus_req_, (k <= c) ? 1'b0 : 1'b1);
      if (k == c) begin
        check("done_busy", busy, 1'b0);
        check("done_out", out, exp_res);
      end
      if (k > c) begin
        check("stall_busy", busy, 1'b0);
        if (load) check("stall_out", out, rdata);
      end
      tick();
    end
    idle_in();
    @(negedge clk);
    check("post_out", out, ex_out);
    check("post_busy", busy, 1'b0);
    check("post_req", bus_req_, 1'b1);
    check("as_count", as_cnt, 1);
    check("busy_count", busy_cnt, c);
    tick();
  endtask

  task automatic flush_req(input int f);
    idle_in();
    ex_en       = 1'b1;
    ex_mem_op   = 2'b01;
    ex_mem_addr = $urandom & 32'hFFFF_FFFC;
    for (int k = 0; k <= f + 2; k++) begin
      flush = (k == f + 1);
      if (k > f) ex_en = 1'b0;
      @(negedge clk);
      check("flush_as", bus_as_, 1'b1);
      if (k >= 1 && k <= f + 1) begin
        check("flush_req_hold", bus_req_, 1'b0);
        check("flush_busy_hold", busy, 1'b1);
      end
      if (k == f + 2) begin
        check("flush_req_drop", bus_req_, 1'b1);
        check("flush_idle", busy, 1'b0);
      end
      tick();
    end
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic timeout_test();
    int err_cnt;
    err_cnt = 0;
    idle_in();
    ex_en       = 1'b1;
    ex_mem_op   = 2'b01;
    ex_mem_addr = 32'h0000_0300;
    bus_grant_  = 1'b0;
    for (int k = 0; k <= TMO + 3; k++) begin
      if (k > TMO + 1) ex_en = 1'b0;
      @(negedge clk);
      if (bus_err) err_cnt++;
      if (k < TMO + 1) check("tmo_busy", busy, 1'b1);
      if (k == TMO + 1) begin
        check("tmo_exp_busy", busy, 1'b0);
        check("tmo_exp_out", out, 32'd0);
      end
      if (k == TMO + 2) begin
        check("tmo_err", bus_err, 1'b1);
        check("tmo_req", bus_req_, 1'b1);
        check("tmo_idle_busy", busy, 1'b0);
      end
      tick();
    end
    check("tmo_err_count", err_cnt, 1);
    idle_in();
  endtask
`endif

  task automatic reset_mid();
    idle_in();
    ex_en       = 1'b1;
    ex_mem_op   = 2'b10;
    ex_mem_addr = 32'h0000_0040;
    tick();
    ex_en = 1'b0;
    @(negedge clk);
    check("rst_pre_req", bus_req_, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_req_async", bus_req_, 1'b1);
    check("rst_busy_async", busy, 1'b0);
    check("rst_addr_async", {2'b00, bus_addr}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_post_req", bus_req_, 1'b1);
    check("rst_post_as", bus_as_, 1'b1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_in();
    ex_out = 32'h55AA_33CC;
    #3;
    check("rst_req", bus_req_, 1'b1);
    check("rst_as", bus_as_, 1'b1);
    check("rst_rw", bus_rw, 1'b1);
    check("rst_addr", {2'b00, bus_addr}, 32'd0);
    check("rst_wdata", bus_wr_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", bus_err, 1'b0);
    check("rst_out", out, 32'h55AA_33CC);
    tick();
    tick();
    reset = 1'b0;

    pass_through(1'b1, 2'b00, 32'h1234_5678);
    pass_through(1'b1, 2'b11, 32'h8765_4321);
    run_access(1'b1, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    run_access(1'b0, 32'h0000_0200, 32'hCAFE_0001, 32'h0, 0, 0, 3, 1'b0);
    misaligned(1'b1, 32'h0000_0102, 1'b0);
    misaligned(1'b0, 32'h0000_0203, 1'b1);
    flush_req(2);
    run_access(1'b1, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1, 2, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: pass_through(1'($urandom), 2'($urandom_range(0, 1) * 3), $urandom);
        1: misaligned(1'($urandom), ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)),
                      1'($urandom));
        2: run_access(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
        default: flush_req($urandom_range(0, 3));
      endcase
    end

`ifdef MEM_BUS_TIMEOUT_EN
    timeout_test();
`else
    run_access(1'b1, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 0, 20, 0, 1'b0);
    check("no_err_default", bus_err, 1'b0);
`endif

    reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- MEM-stage memory access controller. It sits between the EX/MEM pipeline register and the shared system bus, and is the producer side of the MEM/WB register inputs.
- It decodes the load/store request, checks word alignment, and runs the bus master handshake.
- It returns the read data, or passes through the ALU result, on `out`, and flags `miss_align`.
- It asserts `busy` to stall the pipeline while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS-state cycles before abort. Used only with the optional feature; range 1..255, 8-bit counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  pipeline stall from the control unit
- flush  input  1  pipeline flush from the control unit
- ex_en  input  1  EX/MEM entry valid
- ex_mem_op  input  2  00 NOP, 01 LDW, 10 STW, 11 reserved (treated as NOP)
- ex_mem_addr  input  32  byte address from the ALU
- ex_mem_wr_data  input  32  store data
- ex_out  input  32  ALU result for non-memory instructions
- out  output  32  result to MEM/WB
- miss_align  output  1  misaligned access
- busy  output  1  stall request to the control unit
- bus_req_  output  1  bus request, active-low
- bus_grant_  input  1  bus grant, active-low
- bus_as_  output  1  address strobe, active-low, one cycle
- bus_rw  output  1  1 = read, 0 = write
- bus_addr  output  30  word address
- bus_wr_data  output  32  write data
- bus_rd_data  input  32  read data
- bus_rdy_  input  1  transfer complete, active-low
- bus_err  output  1  timeout abort pulse; tied 0 when the optional feature is off

Behaviour:
- One clock `clk`; asynchronous active-high reset `reset`. Registers clear on reset assertion regardless of the clock.
- Reset values:
  - state = IDLE
  - bus_req_ = 1, bus_as_ = 1, bus_rw = 1
  - bus_addr = 0, bus_wr_data = 0
  - rd_buf = 0, timeout counter = 0, bus_err = 0
  - busy = 0
  - out = ex_out (combinational, IDLE path)
- Combinational decode:
  - mem_acc = ex_en & (op == LDW | op == STW)
  - miss_align = mem_acc & (ex_mem_addr[1:0] != 0)
  - valid = mem_acc & ~miss_align & ~flush
- `out` by state:
  - IDLE, no access: ex_out
  - IDLE, misaligned: 0
  - ACCESS completion cycle of a load: bus_rd_data
  - STALL state: rd_buf
  - stores: 0
- IDLE:
  - If valid: bus_req_ <= 0, latch bus_addr = ex_mem_addr[31:2], bus_rw = (op == LDW), bus_wr_data; go to REQ.
  - busy is asserted combinationally in the same cycle.
  - Otherwise remain in IDLE with busy = 0.
- REQ:
  - busy = 1.
  - If flush: bus_req_ <= 1, go to IDLE.
  - Else if bus_grant_ == 0: bus_as_ <= 0 for exactly one cycle, go to ACCESS.
- ACCESS:
  - bus_as_ = 1; busy = 1 until bus_rdy_ == 0.
  - flush is ignored: a started transaction always completes.
  - On bus_rdy_ == 0:
    - bus_req_ <= 1 and rd_buf <= bus_rd_data.
    - busy = 0 in that same cycle; out = bus_rd_data for loads.
    - Next state is STALL if stall is high, else IDLE.
- STALL:
  - busy = 0; out = rd_buf (result held for the stalled pipeline).
  - Leave to IDLE when stall is low.
- Simultaneous miss_align and flush: miss_align is still reported; no bus activity starts.
- Reset mid-transaction: all strobes return inactive immediately; the arbiter sees the request drop.
- Back-to-back accesses:
  - A new request can start only from IDLE, so the minimum per access is REQ → ACCESS → IDLE.
  - With grant held and rdy_ in the first ACCESS cycle, an access costs 3 cycles.

Optional Feature:
- MEM_BUS_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without bus_rdy_.
  - When it reaches TIMEOUT_CYCLES: bus_req_ <= 1, bus_err pulses 1 for one cycle, busy = 0, out = 0, next state IDLE.
  - bus_rdy_ arriving in the same cycle as expiry takes priority: normal completion, no error.
- Undefined: no counter; bus_err is constant 0; ACCESS waits indefinitely.

Test Plan:
- ALU pass-through: ex_en = 1, op = NOP, ex_out = 0x1234_5678 → out = 0x1234_5678, busy = 0, bus_req_ = 1 throughout.
- Load: op = LDW, addr = 0x0000_0104, grant immediate, rdy_ on the 1st ACCESS cycle with rd_data = 0xDEAD_BEEF:
  - bus_addr = 0x41, bus_rw = 1, as_ pulsed once
  - out = 0xDEAD_BEEF on the rdy cycle; busy high for exactly 2 cycles
- Store plus stall: op = STW, addr = 0x200, data = 0xCAFE_0001, stall held 3 cycles after rdy_:
  - bus_rw = 0, bus_wr_data = 0xCAFE_0001
  - state STALL for 3 cycles, busy = 0, then IDLE
- Misaligned: op = LDW, addr = 0x0000_0102 → miss_align = 1, out = 0, no bus_req_ assertion.
- Flush in REQ with grant withheld:
  - flush pulse → bus_req_ returns to 1 next cycle, IDLE, no as_.
  - A repeat with flush during ACCESS still completes on rdy_.
- Timeout (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4), rdy_ never asserted → bus_err = 1 exactly once after the 4th ACCESS cycle, busy = 0, bus_req_ = 1, state IDLE.
